// File: rtl/dm_store_buffer_pkg.sv
// Shared types and helpers for the MEM-stage store buffer.
package dm_store_buffer_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  wlen;
    logic [31:0] pc;
  } sb_entry_t;

  localparam logic [1:0] WLEN_BYTE = 2'd0;
  localparam logic [1:0] WLEN_HALF = 2'd1;
  localparam logic [1:0] WLEN_TRI  = 2'd2;
  localparam logic [1:0] WLEN_WORD = 2'd3;

  // Word index of a byte address, truncated to the low adrbits word bits.
  function automatic logic [31:0] word_index(input logic [31:0] addr,
                                             input int unsigned adrbits);
    logic [31:0] mask;
    mask = (32'd1 << adrbits) - 32'd1;
    return (addr >> 2) & mask;
  endfunction

endpackage

// File: rtl/dm_sb_fifo.sv
// Generic circular FIFO of store entries with a flat view of all live slots.
module dm_sb_fifo
  import dm_store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  sb_entry_t din,
  input  logic      pop,
  output sb_entry_t head_entry,
  output logic      full,
  output logic      empty,
  output sb_entry_t entries [DEPTH],
  output logic [DEPTH-1:0] valid
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0] head, tail;
  logic [PW:0]   count;
  sb_entry_t     mem [DEPTH];
  logic          do_push, do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + 1'b1;
      if (do_pop)  head <= head + 1'b1;
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[tail] <= din;
  end

  assign head_entry = mem[head];
  assign entries    = mem;

  // A slot is live when its distance from head (mod DEPTH) is below count.
  always_comb begin
    valid = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      logic [PW-1:0] offset;
      offset   = PW'(i) - head;
      valid[i] = ({1'b0, offset} < count);
    end
  end

endmodule

// File: rtl/dm_store_buffer.sv
// Store queue between MEM and data memory: drains one store per cycle,
// yields the bus to loads, and stalls loads that hit a pending store word.
module dm_store_buffer
  import dm_store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ADRBITS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_wdata,
  input  logic [1:0]  st_wlen,
  input  logic [31:0] st_pc,
  output logic        st_err,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  output logic        ld_stall,
  output logic [31:0] dm_A,
  output logic [31:0] dm_WD,
  output logic        dm_WE,
  output logic [1:0]  dm_WLen,
  output logic [31:0] dm_PC,
  output logic        empty
);

  sb_entry_t        din, head_entry;
  sb_entry_t        entries [DEPTH];
  logic [DEPTH-1:0] valid;
  logic             full, legal, push, drain, ld_owns;

  assign legal    = ({1'b0, st_addr[1:0]} + {1'b0, st_wlen}) <= {1'b0, WLEN_WORD};
  assign st_ready = !full;
  assign push     = st_valid && st_ready && legal;
  assign din      = '{addr: st_addr, wdata: st_wdata, wlen: st_wlen, pc: st_pc};

  dm_sb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .din        (din),
    .pop        (drain),
    .head_entry (head_entry),
    .full       (full),
    .empty      (empty),
    .entries    (entries),
    .valid      (valid)
  );

  always_comb begin
    ld_stall = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid[i] && ld_valid &&
          word_index(entries[i].addr, ADRBITS) == word_index(ld_addr, ADRBITS))
        ld_stall = 1'b1;
    end
  end

  assign ld_owns = ld_valid && !ld_stall;
  // Drain is also gated by reset so a write never lands in the reset cycle.
  assign drain   = !ld_owns && !empty && reset;

  always_comb begin
    dm_A    = ld_addr;
    dm_WD   = '0;
    dm_WLen = WLEN_BYTE;
    dm_PC   = '0;
    dm_WE   = 1'b0;
    if (!ld_owns && !empty) begin
      dm_A    = head_entry.addr;
      dm_WD   = head_entry.wdata;
      dm_WLen = head_entry.wlen;
      dm_PC   = head_entry.pc;
      dm_WE   = drain;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) st_err <= 1'b0;
    else        st_err <= st_valid && st_ready && !legal;
  end

endmodule
